// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with word-serial line refill.
module icache_dm #(
  parameter int unsigned NUM_LINES      = 16,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned ADDR_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic [31:0]           cpu_instr,
  output logic                  cpu_stall,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_req,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready
);

  localparam int unsigned INDEX_BITS  = $clog2(NUM_LINES);
  localparam int unsigned OFFSET_BITS = $clog2(WORDS_PER_LINE);
  localparam int unsigned TAG_BITS    = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS - 2;

  typedef enum logic {
    S_IDLE,
    S_REFILL
  } state_e;

  state_e                 state_q, state_d;
  logic [OFFSET_BITS-1:0] wcnt_q, wcnt_d;
  logic [TAG_BITS-1:0]    refill_tag_q, refill_tag_d;
  logic [INDEX_BITS-1:0]  refill_index_q, refill_index_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d;

  // Line storage; contents are qualified by valid_q so they carry no reset.
  logic [31:0]         data_mem [NUM_LINES][WORDS_PER_LINE];
  logic [TAG_BITS-1:0] tag_mem  [NUM_LINES];

  logic                   data_we;
  logic                   tag_we;
  logic                   hit;
  logic [OFFSET_BITS-1:0] cpu_offset;
  logic [INDEX_BITS-1:0]  cpu_index;
  logic [TAG_BITS-1:0]    cpu_tag;
  logic                   addr_lsb_unused;

  // Split the fetch address into offset / index / tag fields.
  always_comb begin
    cpu_offset      = cpu_addr[OFFSET_BITS+1:2];
    cpu_index       = cpu_addr[OFFSET_BITS+2 +: INDEX_BITS];
    cpu_tag         = cpu_addr[ADDR_WIDTH-1 -: TAG_BITS];
    addr_lsb_unused = ^cpu_addr[1:0];
  end

  // Hit lookup and array read path, both purely combinational from cpu_addr.
  always_comb begin
    hit       = valid_q[cpu_index] && (tag_mem[cpu_index] == cpu_tag);
    cpu_instr = data_mem[cpu_index][cpu_offset];
  end

  // Next-state, refill bookkeeping and handshake outputs.
  always_comb begin
    state_d        = state_q;
    wcnt_d         = wcnt_q;
    refill_tag_d   = refill_tag_q;
    refill_index_d = refill_index_q;
    valid_d        = valid_q;
    data_we        = 1'b0;
    tag_we         = 1'b0;
    cpu_stall      = 1'b1;
    mem_req        = 1'b0;
    mem_addr       = '0;

    case (state_q)
      S_IDLE: begin
        cpu_stall = !hit;
        if (!hit) begin
          refill_tag_d   = cpu_tag;
          refill_index_d = cpu_index;
          wcnt_d         = '0;
          state_d        = S_REFILL;
        end
      end
      S_REFILL: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = {refill_tag_q, refill_index_q, wcnt_q, 2'b00};
        if (mem_ready) begin
          data_we = 1'b1;
          wcnt_d  = OFFSET_BITS'(wcnt_q + 1'b1);
          if (wcnt_q == OFFSET_BITS'(WORDS_PER_LINE - 1)) begin
            tag_we                  = 1'b1;
            valid_d[refill_index_q] = 1'b1;
            state_d                 = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Reset holds the core off and drops the memory request immediately.
    if (rst) begin
      cpu_stall = 1'b1;
      mem_req   = 1'b0;
      data_we   = 1'b0;
      tag_we    = 1'b0;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      wcnt_q         <= '0;
      refill_tag_q   <= '0;
      refill_index_q <= '0;
      valid_q        <= '0;
    end else begin
      state_q        <= state_d;
      wcnt_q         <= wcnt_d;
      refill_tag_q   <= refill_tag_d;
      refill_index_q <= refill_index_d;
      valid_q        <= valid_d;
    end
  end

  // Data and tag array writes during refill.
  always_ff @(posedge clk) begin
    if (data_we) begin
      data_mem[refill_index_q][wcnt_q] <= mem_rdata;
    end
    if (tag_we) begin
      tag_mem[refill_index_q] <= refill_tag_q;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed tables plus randomized fetches.
module tb_icache_dm;

  localparam int unsigned NL  = 16;
  localparam int unsigned WPL = 4;
  localparam int unsigned AW  = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] cpu_addr = '0;
  logic [31:0]   cpu_instr;
  logic          cpu_stall;
  logic [AW-1:0] mem_addr;
  logic          mem_req;
  logic [31:0]   mem_rdata = '0;
  logic          mem_ready = 1'b0;

  icache_dm #(.NUM_LINES(NL), .WORDS_PER_LINE(WPL), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_instr (cpu_instr),
    .cpu_stall (cpu_stall),
    .mem_addr  (mem_addr),
    .mem_req   (mem_req),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  int          lat       = 2;
  bit          rnd_ready = 1'b0;
  int          wait_cnt  = 0;
  logic [31:0] prev_addr = '0;
  logic        prev_req  = 1'b0;
  logic [31:0] acc_q[$];
  int          cyc          = 0;
  int          last_acc_cyc = -10;
  int          n_chk  = 0;
  int          n_pass = 0;

  // Instruction memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a >> 2;
    return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endfunction

  // Memory responder: ready after `lat` cycles on a new address, or randomly.
  always @(negedge clk) begin
    if (mem_req && prev_req && mem_addr == prev_addr) wait_cnt++;
    else wait_cnt = 0;
    prev_req  = mem_req;
    prev_addr = mem_addr;
    mem_ready = mem_req && (rnd_ready ? ($urandom_range(0, 2) == 0) : (wait_cnt >= lat));
    mem_rdata = mem_ready ? mem_word(mem_addr) : 32'hDEAD_BEEF;
  end

  // Log every accepted refill word and the cycle it was accepted in.
  always @(posedge clk) begin
    if (!rst && mem_req && mem_ready) begin
      acc_q.push_back(mem_addr);
      last_acc_cyc = cyc;
    end
    cyc++;
  end

  // One fetch: check stall against expectation, wait out any refill, check data.
  task automatic fetch(input logic [31:0] a, input bit exp_miss, input string nm, output int pen);
    logic [31:0] base;
    base = a & 32'hFFFF_FFF0;
    pen  = 0;
    acc_q.delete();
    cpu_addr = a;
    @(negedge clk);
    chk({nm, " stall"}, 32'(cpu_stall), 32'(exp_miss));
    if (cpu_stall) begin
      while (cpu_stall && pen < 400) begin
        @(negedge clk);
        pen++;
      end
      chk({nm, " refill done"}, 32'(cpu_stall), 32'h0);
      chk({nm, " refill words"}, 32'(acc_q.size()), 32'(WPL));
      for (int i = 0; i < acc_q.size() && i < WPL; i++)
        chk({nm, " refill addr"}, acc_q[i], base + 32'(4 * i));
      chk({nm, " stall drop cycle"}, 32'(cyc), 32'(last_acc_cyc + 1));
    end
    chk({nm, " instr"}, cpu_instr, mem_word(a & 32'hFFFF_FFFC));
    chk({nm, " req idle"}, 32'(mem_req), 32'h0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        exp_stall;
    logic        exp_req;
    logic [31:0] exp_instr;
  } hit_vec_t;

  typedef struct {
    logic [31:0] addr;
    bit          miss;
  } fetch_vec_t;

  hit_vec_t    hv[4];
  fetch_vec_t  cv[6];
  logic [31:0] line_of[int];
  logic [31:0] exp_seq[8];
  int          pen;
  int          k;
  int          idx;
  logic [31:0] ra, rbase;
  bit          rmiss;

  initial begin
    hv[0] = '{32'h4, 1'b0, 1'b0, mem_word(32'h4)};
    hv[1] = '{32'h8, 1'b0, 1'b0, mem_word(32'h8)};
    hv[2] = '{32'hC, 1'b0, 1'b0, mem_word(32'hC)};
    hv[3] = '{32'h0, 1'b0, 1'b0, mem_word(32'h0)};
    cv[0] = '{32'h000, 1'b0};
    cv[1] = '{32'h100, 1'b1};
    cv[2] = '{32'h104, 1'b0};
    cv[3] = '{32'h000, 1'b1};
    cv[4] = '{32'h10C, 1'b1};
    cv[5] = '{32'h008, 1'b1};

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset stall", 32'(cpu_stall), 32'h1);
    chk("reset req", 32'(mem_req), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset req", 32'(mem_req), 32'h0);
    chk("post-reset addr", mem_addr, 32'h0);
    chk("post-reset stall", 32'(cpu_stall), 32'h1);
    @(posedge clk); #1;

    // First fill of line 0 with two-cycle memory latency.
    fetch(32'h0, 1'b1, "fill0", pen);

    // Back-to-back hits in the filled line.
    for (int i = 0; i < 4; i++) begin
      cpu_addr = hv[i].addr;
      @(negedge clk);
      chk("hit stall", 32'(cpu_stall), 32'(hv[i].exp_stall));
      chk("hit req", 32'(mem_req), 32'(hv[i].exp_req));
      chk("hit instr", cpu_instr, hv[i].exp_instr);
      @(posedge clk); #1;
    end

    // Conflict misses on index 0.
    for (int i = 0; i < 6; i++) fetch(cv[i].addr, cv[i].miss, "conflict", pen);

    // Memory always ready: minimum miss penalty and word placement.
    lat = 0;
    fetch(32'h40, 1'b1, "fast", pen);
    chk("fast penalty", 32'(pen), 32'(WPL + 1));
    fetch(32'h44, 1'b0, "fast w1", pen);
    fetch(32'h48, 1'b0, "fast w2", pen);
    fetch(32'h4C, 1'b0, "fast w3", pen);

    // Reset while the second word of line 0x80 is outstanding.
    lat = 2;
    acc_q.delete();
    cpu_addr = 32'h80;
    k = 0;
    while (acc_q.size() < 1 && k < 50) begin
      @(posedge clk);
      k++;
    end
    chk("abort first word", 32'(acc_q.size()), 32'h1);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort rst stall", 32'(cpu_stall), 32'h1);
    chk("abort rst req", 32'(mem_req), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort next req", 32'(mem_req), 32'h0);
    chk("abort next addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    fetch(32'h80, 1'b1, "abort refetch", pen);
    fetch(32'h000, 1'b1, "post-reset line0", pen);

    // PC moves to 0x200 while line 0x20 is refilling.
    acc_q.delete();
    cpu_addr = 32'h20;
    repeat (3) @(posedge clk);
    #1;
    cpu_addr = 32'h200;
    pen = 0;
    @(negedge clk);
    while (cpu_stall && pen < 400) begin
      @(negedge clk);
      pen++;
    end
    for (int i = 0; i < 4; i++) begin
      exp_seq[i]     = 32'h20 + 32'(4 * i);
      exp_seq[i + 4] = 32'h200 + 32'(4 * i);
    end
    chk("redirect done", 32'(cpu_stall), 32'h0);
    chk("redirect words", 32'(acc_q.size()), 32'h8);
    for (int i = 0; i < acc_q.size() && i < 8; i++) chk("redirect addr", acc_q[i], exp_seq[i]);
    chk("redirect instr", cpu_instr, mem_word(32'h200));
    @(posedge clk); #1;
    fetch(32'h24, 1'b0, "redirect old line", pen);
    fetch(32'h204, 1'b0, "redirect new line", pen);

    // Randomized fetches against a line-ownership model.
    rst = 1'b1;
    cpu_addr = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    line_of.delete();
    rnd_ready = 1'b1;
    for (int n = 0; n < 120; n++) begin
      ra    = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4)
            | 32'($urandom_range(0, 15));
      rbase = ra & 32'hFFFF_FFF0;
      idx   = int'((ra >> 4) % NL);
      rmiss = !(line_of.exists(idx) && line_of[idx] == rbase);
      fetch(ra, rmiss, "rand", pen);
      line_of[idx] = rbase;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Backstop against a stuck run.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
